mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Arbitrates the instruction-fetch and data-memory request lines from the request unit onto a single shared RAM port, one access at a time. Data requests win by default, with alternation whenever both sides are pending. The block tracks the RAM handshake state and returns registered read data. It generates single-cycle ihit/dhit pulses, which the request unit uses to drop its held dmemREN/dmemWEN. A watchdog aborts accesses the RAM never completes.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 64, max cycles spent in an access state before abort (≥2)

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  reset, synchronous, active-low
iREN  in  1  instruction read request (level, held until ihit)
iaddr  in  AW  instruction address
ihit  out  1  one-cycle pulse: iload valid
iload  out  DW  instruction read data, registered
dREN  in  1  data read request (level, held until dhit)
dWEN  in  1  data write request (level, held until dhit)
daddr  in  AW  data address
dstore  in  DW  data write value
dhit  out  1  one-cycle pulse: data access complete
dload  out  DW  data read data, registered
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  AW  RAM address
ramstore  out  DW  RAM write data
ramload  in  DW  RAM read data, valid when ramstate==ACCESS
ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3
err  out  1  sticky abort flag

Behaviour:
- Reset: synchronous; sampled on the CLK edge while nRST=0.
  - All outputs are 0 after reset: ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err.
  - Reset values: state=IDLE, wait_cnt=0, last_d=0.
  - Reset mid-access abandons the access with no hit.
- FSM states: IDLE, DACC, IACC, RESP.
- IDLE:
  - Grant rule when both pending: data if last_d=0, else instruction. Otherwise grant whichever side is pending.
  - On a grant, capture the address (plus dstore and the read/write direction for data) into internal registers and move to DACC or IACC. Set last_d to 1 for a data grant, 0 for an instruction grant.
  - If dREN and dWEN are both high, treat the request as a write.
- DACC/IACC:
  - ram* outputs are driven combinationally from the captured registers and stay stable for the whole state.
  - ramREN/ramWEN are 0 in IDLE and RESP.
  - Input changes during an access are ignored.
- Completion: ramstate==ACCESS in an access state. At that clock edge:
  - latch ramload into dload (data read) or iload; a write leaves dload unchanged;
  - set the matching hit register;
  - go to RESP.
- RESP: lasts exactly 1 cycle with the hit high, then returns to IDLE with the hit cleared.
  - No new grant is made in RESP. The requester's level is still high that cycle, so this prevents a duplicate access.
  - Minimum issue-to-hit latency is 2 cycles: grant edge, then ACCESS on the first access cycle, then the hit visible in the next cycle.
- Abort: triggered by ramstate==ERROR in an access state, or wait_cnt==TIMEOUT-1 without ACCESS.
  - Set err, return to IDLE, assert no hit.
  - The requester is still asserting, so the access is re-arbitrated. last_d is retained.
- wait_cnt: cleared on entering an access state, increments each cycle in an access state, saturates at TIMEOUT-1.
- err: cleared only by reset.
- Outputs ihit, dhit, iload, dload and err are registered. ram* outputs are a function of state and the captured registers only; there is no combinational path from the requester inputs.
- A requester that drops its request mid-access still gets the access completed and the hit pulsed.
- Data or instruction load values hold until the next read of the same type completes.

Test Plan:
- Reset: nRST=0 for 2 cycles with all requests high -> all outputs 0; the first grant occurs on the edge after nRST=1.
- Instruction read: iREN=1, iaddr=0x00000040; ramstate goes BUSY,BUSY then ACCESS with ramload=0x8C220004 -> ramREN=1 and ramaddr=0x40 for 3 cycles; ihit=1 and iload=0x8C220004 for exactly 1 cycle; no second access while iREN is still high in the RESP cycle.
- Contention: iREN=1 held; dWEN=1, daddr=0x100, dstore=0xDEADBEEF, RAM completes each access on its first cycle -> grants alternate data, instr, data. The write shows ramWEN=1, ramstore=0xDEADBEEF, dhit pulses, and dload is unchanged.
- Timeout: dREN=1 with ramstate held BUSY -> exactly TIMEOUT (64) cycles in DACC, err=1, no dhit, then the access is re-issued. err stays 1 until reset.
- ERROR response: ramstate=ERROR on the first cycle of IACC -> return to IDLE next cycle, err=1, ihit stays 0.
- Reset mid-access: nRST=0 during DACC with ramstate=BUSY -> next cycle IDLE, ramREN=0, no dhit, err=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and data access.
// Grants alternate under contention, and a watchdog aborts stalled accesses.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          iREN,
    input  logic [AW-1:0] iaddr,
    output logic          ihit,
    output logic [DW-1:0] iload,
    input  logic          dREN,
    input  logic          dWEN,
    input  logic [AW-1:0] daddr,
    input  logic [DW-1:0] dstore,
    output logic          dhit,
    output logic [DW-1:0] dload,
    output logic          ramREN,
    output logic          ramWEN,
    output logic [AW-1:0] ramaddr,
    output logic [DW-1:0] ramstore,
    input  logic [DW-1:0] ramload,
    input  logic [1:0]    ramstate,
    output logic          err
);

    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;
    localparam int         CW        = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, DACC, IACC, RESP} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_wait_cnt;
    logic          r_last_d;
    logic          r_wr;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_store;
    logic [DW-1:0] r_iload;
    logic [DW-1:0] r_dload;
    logic          r_ihit;
    logic          r_dhit;
    logic          r_err;

    logic w_dreq;
    logic w_grant_d;
    logic w_grant_i;
    logic w_in_acc;
    logic w_done;
    logic w_timeout;
    logic w_abort;

    // Data wins unless it won last time and the instruction side is also waiting.
    assign w_dreq    = dREN | dWEN;
    assign w_grant_d = (r_state == IDLE) & w_dreq & (~iREN | ~r_last_d);
    assign w_grant_i = (r_state == IDLE) & iREN & ~w_grant_d;
    assign w_in_acc  = (r_state == DACC) | (r_state == IACC);
    assign w_done    = w_in_acc & (ramstate == RS_ACCESS);
    assign w_timeout = (r_wait_cnt == CNT_MAX);
    assign w_abort   = w_in_acc & ~w_done & ((ramstate == RS_ERROR) | w_timeout);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_next = DACC;
                end else if (w_grant_i) begin
                    w_next = IACC;
                end
            end
            DACC, IACC: begin
                if (w_done) begin
                    w_next = RESP;
                end else if (w_abort) begin
                    w_next = IDLE;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // RAM side depends only on state and captured request, never on live inputs.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (r_state)
            DACC: begin
                ramREN   = ~r_wr;
                ramWEN   = r_wr;
                ramaddr  = r_addr;
                ramstore = r_store;
            end
            IACC: begin
                ramREN  = 1'b1;
                ramaddr = r_addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_wait_cnt <= '0;
            r_last_d   <= 1'b0;
            r_wr       <= 1'b0;
            r_addr     <= '0;
            r_store    <= '0;
            r_iload    <= '0;
            r_dload    <= '0;
            r_ihit     <= 1'b0;
            r_dhit     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_grant_d | w_grant_i) begin
                r_addr     <= w_grant_d ? daddr : iaddr;
                r_store    <= dstore;
                r_wr       <= w_grant_d & dWEN;
                r_last_d   <= w_grant_d;
                r_wait_cnt <= '0;
            end else if (w_in_acc && !w_timeout) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            r_ihit <= (r_state == IACC) & w_done;
            r_dhit <= (r_state == DACC) & w_done;
            if ((r_state == IACC) && w_done) begin
                r_iload <= ramload;
            end
            // A completed write leaves the last read value in dload.
            if ((r_state == DACC) && w_done && !r_wr) begin
                r_dload <= ramload;
            end
            if (w_abort) begin
                r_err <= 1'b1;
            end
        end
    end

    assign ihit  = r_ihit;
    assign dhit  = r_dhit;
    assign iload = r_iload;
    assign dload = r_dload;
    assign err   = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random transactions
// predicted by a transaction-level model of the grant and handshake rules.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TIMEOUT = 64;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          iREN;
    logic [AW-1:0] iaddr;
    logic          ihit;
    logic [DW-1:0] iload;
    logic          dREN;
    logic          dWEN;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dstore;
    logic          dhit;
    logic [DW-1:0] dload;
    logic          ramREN;
    logic          ramWEN;
    logic [AW-1:0] ramaddr;
    logic [DW-1:0] ramstore;
    logic [DW-1:0] ramload;
    logic [1:0]    ramstate;
    logic          err;

    int n_total = 0;
    int n_pass  = 0;

    logic          m_last_d;
    logic          m_win_d;
    logic          exp_err;
    logic [DW-1:0] exp_iload;
    logic [DW-1:0] exp_dload;

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dhit(dhit), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ramREN"}, ramREN, 1'b0);
        chk({tag, "_ramWEN"}, ramWEN, 1'b0);
        chk({tag, "_ihit"}, ihit, 1'b0);
        chk({tag, "_dhit"}, dhit, 1'b0);
        chk({tag, "_iload"}, iload, exp_iload);
        chk({tag, "_dload"}, dload, exp_dload);
        chk({tag, "_err"}, err, exp_err);
    endtask

    // Called in an IDLE cycle with requests set; grant happens on the next edge.
    task automatic run_access(input int lat, input logic [DW-1:0] rdata);
        logic          win_d;
        logic          wr;
        logic [AW-1:0] a;
        logic [DW-1:0] s;
        win_d = (dREN | dWEN) && (!iREN || !m_last_d);
        wr    = win_d && dWEN;
        a     = win_d ? daddr : iaddr;
        s     = dstore;
        for (int k = 0; k <= lat; k++) begin
            tick();
            ramstate = (k < lat) ? BUSY : ACCESS;
            ramload  = (k < lat) ? DW'($urandom) : rdata;
            if (k == 0) begin
                iaddr  = $urandom;
                daddr  = $urandom;
                dstore = $urandom;
                if ($urandom_range(0, 3) == 0) begin
                    if (win_d) begin
                        dREN = 1'b0;
                        dWEN = 1'b0;
                    end else begin
                        iREN = 1'b0;
                    end
                end
            end
            chk("acc_ramREN", ramREN, !wr);
            chk("acc_ramWEN", ramWEN, wr);
            chk("acc_ramaddr", ramaddr, a);
            if (wr) chk("acc_ramstore", ramstore, s);
            chk("acc_ihit", ihit, 1'b0);
            chk("acc_dhit", dhit, 1'b0);
        end
        tick();
        ramstate = FREE;
        if (!wr) begin
            if (win_d) exp_dload = rdata;
            else       exp_iload = rdata;
        end
        chk("resp_ihit", ihit, !win_d);
        chk("resp_dhit", dhit, win_d);
        chk("resp_iload", iload, exp_iload);
        chk("resp_dload", dload, exp_dload);
        chk("resp_ramREN", ramREN, 1'b0);
        chk("resp_ramWEN", ramWEN, 1'b0);
        chk("resp_err", err, exp_err);
        tick();
        chk_idle("post");
        m_last_d = win_d;
        m_win_d  = win_d;
    endtask

    task automatic drop_winner();
        if (m_win_d) begin
            dREN = 1'b0;
            dWEN = 1'b0;
        end else begin
            iREN = 1'b0;
        end
    endtask

    task automatic random_phase(input int n);
        int r;
        for (int t = 0; t < n; t++) begin
            if (!iREN && $urandom_range(0, 1) == 1) begin
                iREN  = 1'b1;
                iaddr = $urandom;
            end
            if (!(dREN | dWEN) && $urandom_range(0, 1) == 1) begin
                r      = $urandom_range(0, 7);
                dREN   = (r < 4) || (r == 7);
                dWEN   = (r >= 4);
                daddr  = $urandom;
                dstore = $urandom;
            end
            if (!iREN && !(dREN | dWEN)) begin
                iREN  = 1'b1;
                iaddr = $urandom;
            end
            run_access($urandom_range(0, 3), $urandom);
            drop_winner();
        end
    endtask

    initial begin
        nRST = 1'b0; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b1;
        iaddr = 32'h0000_0040; daddr = 32'h0000_0200; dstore = 32'h1234_5678;
        ramload = '0; ramstate = FREE;
        m_last_d = 1'b0; m_win_d = 1'b0; exp_err = 1'b0;
        exp_iload = '0; exp_dload = '0;

        // Reset with every request asserted.
        for (int c = 0; c < 2; c++) begin
            tick();
            chk_idle("rst");
            chk("rst_ramaddr", ramaddr, '0);
            chk("rst_ramstore", ramstore, '0);
        end
        nRST = 1'b1;
        run_access(0, 32'hCAFE_0001);
        drop_winner();

        // Instruction read with two BUSY cycles.
        iREN = 1'b1; iaddr = 32'h0000_0040;
        run_access(2, 32'h8C22_0004);
        drop_winner();

        // Contention: data, instruction, data.
        iREN = 1'b1; iaddr = 32'h0000_0080;
        dWEN = 1'b1; daddr = 32'h0000_0100; dstore = 32'hDEAD_BEEF;
        run_access(0, 32'h5555_AAAA);
        drop_winner();
        run_access(0, 32'h0000_1111);
        drop_winner();
        iREN = 1'b1; iaddr = 32'h0000_0084;
        dWEN = 1'b1; daddr = 32'h0000_0100; dstore = 32'hDEAD_BEEF;
        run_access(0, 32'h7777_0000);
        drop_winner();
        iREN = 1'b0;

        // Watchdog: exactly TIMEOUT cycles stuck in BUSY, then re-issue.
        dREN = 1'b1; dWEN = 1'b0; daddr = 32'h0000_0300;
        for (int k = 0; k < TIMEOUT; k++) begin
            tick();
            ramstate = BUSY;
            chk("to_ramREN", ramREN, 1'b1);
            chk("to_dhit", dhit, 1'b0);
            chk("to_err", err, 1'b0);
        end
        tick();
        ramstate = FREE;
        exp_err = 1'b1;
        chk_idle("to_abort");
        run_access(1, 32'hABCD_0123);
        drop_winner();

        random_phase(30);
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        tick();

        // Reset in the middle of a data access.
        dREN = 1'b1; daddr = 32'h0000_0400;
        tick();
        ramstate = BUSY;
        chk("mid_ramREN", ramREN, 1'b1);
        nRST = 1'b0;
        tick();
        ramstate = FREE;
        exp_err = 1'b0; exp_iload = '0; exp_dload = '0; m_last_d = 1'b0;
        chk_idle("mid_rst");
        nRST = 1'b1;
        dREN = 1'b0;
        tick();

        // RAM ERROR on the first instruction access cycle.
        iREN = 1'b1; iaddr = 32'h0000_0500;
        tick();
        ramstate = ERROR;
        chk("er_ramREN", ramREN, 1'b1);
        tick();
        ramstate = FREE;
        exp_err = 1'b1;
        chk_idle("er_abort");
        run_access(0, 32'h0BAD_F00D);
        drop_winner();

        random_phase(20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
